divider_cdb_buffer: RTL and testbench

- Sits directly downstream of the 32-stage pipelined unsigned divider and upstream of the common data bus (CDB) arbiter.
- Tracks every issued divide through a latency-matched valid delay line and captures the divider output on the matching cycle.
- Selects quotient or remainder per op and holds results in a FIFO until the CDB grants a slot.
- Drives issue back-pressure (can_issue) so the non-stallable divider pipeline can never overflow the FIFO.

---
 rtl/divider_cdb_buffer.sv | 143 ++++++++++++++
 tb/tb_divider_cdb_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_cdb_buffer.sv
`default_nettype none
// ============================================================================
// divider_cdb_buffer : latency-matched capture of divider results into a
//                      first-word-fall-through FIFO feeding the CDB arbiter
// Revision: 1.0
// ============================================================================
module divider_cdb_buffer #(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   start_in,
  input  logic [31:0]            div_quotient,
  input  logic [31:0]            div_remainder,
  input  logic                   div_op,
  input  logic [6:0]             div_phys_addr,
  input  logic [31:0]            div_pc,
  input  logic                   cdb_grant,
  output logic                   cdb_req,
  output logic [31:0]            cdb_result,
  output logic [6:0]             cdb_phys_addr,
  output logic [31:0]            cdb_pc,
  output logic                   can_issue,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(LATENCY) + 1;
  localparam int EW = 32 + 7 + 32;

  logic [LATENCY-1:0] delay_q, delay_d;
  logic [FW-1:0]      in_flight_q, in_flight_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [EW-1:0]      mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               tap;
  logic               full;
  logic               capture;
  logic               pop;
  logic               push;
  logic [EW-1:0]      capture_entry;
  logic [EW-1:0]      head_entry;
  logic [31:0]        occupancy;

  always_comb begin
    tap           = delay_q[LATENCY-1];
    full          = (count_q == (AW+1)'(DEPTH));
    cdb_req       = (count_q != '0);
    // Everything arriving in a flush cycle is discarded, including the pop.
    pop           = cdb_req & cdb_grant & ~flush;
    capture       = tap & ~flush;
    push          = capture & (~full | pop);
    capture_entry = {(div_op ? div_remainder : div_quotient), div_phys_addr, div_pc};
    head_entry    = mem_q[rd_ptr_q];

    delay_d = flush ? '0 : {delay_q[LATENCY-2:0], start_in};

    in_flight_d = in_flight_q;
    if (flush) begin
      in_flight_d = '0;
    end else begin
      case ({start_in, tap})
        2'b10:   in_flight_d = in_flight_q + 1'b1;
        2'b01:   in_flight_d = in_flight_q - 1'b1;
        default: in_flight_d = in_flight_q;
      endcase
    end

    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = capture_entry;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    overflow_d = overflow_q | (capture & full & ~pop);

    // Ops already issued count against capacity so the unstallable divider
    // can never deliver into a full buffer.
    occupancy = 32'(count_q) + 32'(in_flight_q);
    can_issue = (occupancy < 32'(DEPTH));

    count         = count_q;
    overflow      = overflow_q;
    cdb_result    = cdb_req ? head_entry[70:39] : '0;
    cdb_phys_addr = cdb_req ? head_entry[38:32] : '0;
    cdb_pc        = cdb_req ? head_entry[31:0]  : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      delay_q     <= '0;
      in_flight_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      delay_q     <= delay_d;
      in_flight_q <= in_flight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_cdb_buffer.sv
`default_nettype none
// ============================================================================
// tb_divider_cdb_buffer : directed bench for divider_cdb_buffer with a
//                         simple pipelined-divider model on its inputs
// Revision: 1.0
// ============================================================================
module tb_divider_cdb_buffer;

  localparam int DEPTH   = 8;
  localparam int LATENCY = 32;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        flush     = 1'b0;
  logic        start_in  = 1'b0;
  logic        cdb_grant = 1'b0;
  logic [31:0] op_a      = 32'h0BADF00D;
  logic [31:0] op_b      = 32'd1;
  logic        op_sel    = 1'b0;
  logic [6:0]  op_tag    = 7'h7F;
  logic [31:0] op_pc     = 32'h0000BAD0;

  logic [31:0] div_quotient, div_remainder, div_pc;
  logic        div_op;
  logic [6:0]  div_phys_addr;

  logic        cdb_req, can_issue, overflow;
  logic [31:0] cdb_result, cdb_pc;
  logic [6:0]  cdb_phys_addr;
  logic [3:0]  count;

  int          errors = 0;
  int          checks = 0;
  logic [70:0] exp_q [$];

  // Divider model: every stage shifts each cycle, stage 0 samples the issue operands.
  logic [31:0] m_q   [LATENCY];
  logic [31:0] m_r   [LATENCY];
  logic        m_op  [LATENCY];
  logic [6:0]  m_tag [LATENCY];
  logic [31:0] m_pc  [LATENCY];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_q[0]   <= op_a / op_b;
    m_r[0]   <= op_a % op_b;
    m_op[0]  <= op_sel;
    m_tag[0] <= op_tag;
    m_pc[0]  <= op_pc;
    for (int k = 1; k < LATENCY; k++) begin
      m_q[k]   <= m_q[k-1];
      m_r[k]   <= m_r[k-1];
      m_op[k]  <= m_op[k-1];
      m_tag[k] <= m_tag[k-1];
      m_pc[k]  <= m_pc[k-1];
    end
  end

  assign div_quotient  = m_q[LATENCY-1];
  assign div_remainder = m_r[LATENCY-1];
  assign div_op        = m_op[LATENCY-1];
  assign div_phys_addr = m_tag[LATENCY-1];
  assign div_pc        = m_pc[LATENCY-1];

  divider_cdb_buffer #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .start_in      (start_in),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_op        (div_op),
    .div_phys_addr (div_phys_addr),
    .div_pc        (div_pc),
    .cdb_grant     (cdb_grant),
    .cdb_req       (cdb_req),
    .cdb_result    (cdb_result),
    .cdb_phys_addr (cdb_phys_addr),
    .cdb_pc        (cdb_pc),
    .can_issue     (can_issue),
    .count         (count),
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start_in = 1'b0;
    op_a     = 32'h0BADF00D;
    op_b     = 32'd1;
    op_sel   = 1'b0;
    op_tag   = 7'h7F;
    op_pc    = 32'h0000BAD0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [6:0] tag, input logic [31:0] pc);
    start_in = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sel   = op;
    op_tag   = tag;
    op_pc    = pc;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [6:0] tag, input logic [31:0] pc, input bit record);
    drive(a, b, op, tag, pc);
    if (record) exp_q.push_back({(op ? a % b : a / b), tag, pc});
    tick();
    idle();
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!cdb_req && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_count(input int target, output int n);
    n = 0;
    while (int'(count) != target && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_head(input string tag);
    logic [70:0] e;
    e = exp_q.pop_front();
    check({tag, "_req"},    32'(cdb_req),       32'd1);
    check({tag, "_result"}, cdb_result,         e[70:39]);
    check({tag, "_tag"},    32'(cdb_phys_addr), 32'(e[38:32]));
    check({tag, "_pc"},     cdb_pc,             e[31:0]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},      32'(cdb_req),       32'd0);
    check({tag, "_count"},    32'(count),         32'd0);
    check({tag, "_can_issue"},32'(can_issue),     32'd1);
    check({tag, "_result"},   cdb_result,         32'd0);
    check({tag, "_tag"},      32'(cdb_phys_addr), 32'd0);
    check({tag, "_pc"},       cdb_pc,             32'd0);
    check({tag, "_overflow"}, 32'(overflow),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int accepted;
    bit seen;

    // Reset state
    idle();
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    // Single quotient op, grant held high
    cdb_grant = 1'b1;
    issue(32'd100, 32'd7, 1'b0, 7'd5, 32'h40, 1'b0);
    check("single_can_issue_inflight", 32'(can_issue), 32'd1);
    wait_req(n);
    check("single_latency", 32'(n), 32'd32);
    check("single_result", cdb_result, 32'd14);
    check("single_tag", 32'(cdb_phys_addr), 32'd5);
    check("single_pc", cdb_pc, 32'h40);
    check("single_can_issue", 32'(can_issue), 32'd1);
    tick();
    check("single_req_one_cycle", 32'(cdb_req), 32'd0);

    // Single remainder op
    issue(32'd100, 32'd7, 1'b1, 7'd6, 32'h44, 1'b0);
    wait_req(n);
    check("rem_latency", 32'(n), 32'd32);
    check("rem_result", cdb_result, 32'd2);
    check("rem_tag", 32'(cdb_phys_addr), 32'd6);
    tick();

    // Back-to-back starts, alternating quotient/remainder
    for (int i = 0; i < 4; i++) begin
      issue(32'd100, 32'd7, 1'(i % 2), 7'(i + 1), 32'(32'h100 + 4 * i), 1'b1);
    end
    wait_req(n);
    check("b2b_latency", 32'(n), 32'd29);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("b2b%0d", i));
      tick();
    end
    check("b2b_drained", 32'(cdb_req), 32'd0);

    // Flood with grant low: exactly DEPTH starts accepted
    cdb_grant = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 12; i++) begin
      if (can_issue) begin
        issue(32'(100 + accepted), 32'd7, 1'(accepted % 2), 7'(10 + accepted),
              32'(32'h200 + 4 * accepted), 1'b1);
        accepted++;
      end else begin
        tick();
      end
    end
    check("flood_accepted", 32'(accepted), 32'd8);
    check("flood_can_issue", 32'(can_issue), 32'd0);
    repeat (40) tick();
    check("flood_count", 32'(count), 32'd8);
    check("flood_overflow", 32'(overflow), 32'd0);
    check("flood_can_issue_full", 32'(can_issue), 32'd0);
    check_head("flood_head");
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check("grant_one_count", 32'(count), 32'd7);
    check("grant_one_can_issue", 32'(can_issue), 32'd1);

    // Full buffer, push and pop in the same cycle
    issue(32'd500, 32'd9, 1'b0, 7'd40, 32'h300, 1'b1);
    check("x_can_issue", 32'(can_issue), 32'd0);
    issue(32'd500, 32'd9, 1'b1, 7'd41, 32'h304, 1'b1);
    wait_count(8, n);
    check("full_fill_latency", 32'(n), 32'd31);
    check_head("full_pop_head");
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check("full_pushpop_count", 32'(count), 32'd8);
    check("full_pushpop_overflow", 32'(overflow), 32'd0);

    // Forced start into a full buffer with no pop
    issue(32'd600, 32'd7, 1'b0, 7'd42, 32'h308, 1'b0);
    n = 0;
    while (!overflow && n < 40) begin
      tick();
      n++;
    end
    check("ovf_latency", 32'(n), 32'd32);
    check("ovf_count", 32'(count), 32'd8);
    cdb_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("drain%0d", i));
      tick();
    end
    cdb_grant = 1'b0;
    check("drain_req", 32'(cdb_req), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    check("drain_overflow_sticky", 32'(overflow), 32'd1);

    // Flush with 2 buffered and 3 in flight, plus a start in the flush cycle
    issue(32'd50, 32'd5, 1'b0, 7'd50, 32'h400, 1'b0);
    issue(32'd53, 32'd5, 1'b1, 7'd51, 32'h404, 1'b0);
    wait_count(2, n);
    check("flush_setup_count", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      issue(32'd70, 32'd3, 1'b0, 7'(52 + i), 32'(32'h408 + 4 * i), 1'b0);
    end
    drive(32'd80, 32'd3, 1'b0, 7'd60, 32'h480);
    flush     = 1'b1;
    cdb_grant = 1'b1;
    tick();
    idle();
    flush     = 1'b0;
    cdb_grant = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_req", 32'(cdb_req), 32'd0);
    check("flush_can_issue", 32'(can_issue), 32'd1);
    check("flush_overflow_kept", 32'(overflow), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (cdb_req) seen = 1'b1;
    end
    check("flush_no_capture", 32'(seen), 32'd0);

    // Reset mid-stream: 4 buffered, 2 in flight
    for (int i = 0; i < 4; i++) begin
      issue(32'd90, 32'd4, 1'b0, 7'(70 + i), 32'(32'h600 + 4 * i), 1'b0);
    end
    wait_count(4, n);
    check("rst_setup_count", 32'(count), 32'd4);
    issue(32'd91, 32'd4, 1'b1, 7'd80, 32'h680, 1'b0);
    issue(32'd92, 32'd4, 1'b1, 7'd81, 32'h684, 1'b0);
    reset = 1'b1;
    tick();
    check_reset_state("midrst");
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (cdb_req) seen = 1'b1;
    end
    check("midrst_no_stale", 32'(seen), 32'd0);

    // One clean op after reset
    cdb_grant = 1'b1;
    issue(32'd1000, 32'd33, 1'b1, 7'd9, 32'h500, 1'b0);
    wait_req(n);
    check("post_latency", 32'(n), 32'd32);
    check("post_result", cdb_result, 32'd10);
    check("post_tag", 32'(cdb_phys_addr), 32'd9);
    check("post_pc", cdb_pc, 32'h500);
    tick();
    cdb_grant = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
